// File: rtl/mfrc522_pkg.sv
// Shared constants for the MFRC522 bring-up sequencer: register map, command
// codes, error codes, state encoding and step indices of the init table.
package mfrc522_pkg;

  localparam logic [5:0] REG_COMMAND    = 6'h01;
  localparam logic [5:0] REG_MODE       = 6'h11;
  localparam logic [5:0] REG_TXCONTROL  = 6'h14;
  localparam logic [5:0] REG_TXASK      = 6'h15;
  localparam logic [5:0] REG_TMODE      = 6'h2A;
  localparam logic [5:0] REG_TPRESCALER = 6'h2B;
  localparam logic [5:0] REG_TRELOAD_H  = 6'h2C;
  localparam logic [5:0] REG_TRELOAD_L  = 6'h2D;
  localparam logic [5:0] REG_VERSION    = 6'h37;

  localparam logic [7:0] CMD_SOFTRESET = 8'h0F;
  localparam int         POWERDOWN_BIT = 4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_POLL    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_VERSION = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [3:0] STEP_RMW_READ = 4'd8;
  localparam logic [3:0] STEP_LAST     = 4'd10;

  // Antenna-on bits OR-ed into TxControlReg during the read-modify-write.
  localparam logic [7:0] TXCTRL_ANTENNA_ON = 8'h03;

  // Silicon revisions accepted by the optional version check.
  localparam logic [7:0] VERSION_V1 = 8'h91;
  localparam logic [7:0] VERSION_V2 = 8'h92;

endpackage

// File: rtl/mfrc522_init_rom.sv
// Combinational init-table lookup: step index -> register command fields.
// For the read-modify-write step, wdata is the mask OR-ed into the read value.
module mfrc522_init_rom
  import mfrc522_pkg::*;
(
  input  logic [3:0] step,
  output logic       is_write,
  output logic [5:0] addr,
  output logic [7:0] wdata,
  output logic       is_poll,
  output logic       is_rmw
);

  always_comb begin
    is_write = 1'b0;
    addr     = '0;
    wdata    = '0;
    is_poll  = 1'b0;
    is_rmw   = 1'b0;
    case (step)
      4'd0:  begin is_write = 1'b1; addr = REG_COMMAND;    wdata = CMD_SOFTRESET; end
      4'd1:  begin                  addr = REG_COMMAND;    is_poll = 1'b1;        end
      4'd2:  begin is_write = 1'b1; addr = REG_TMODE;      wdata = 8'h8D;         end
      4'd3:  begin is_write = 1'b1; addr = REG_TPRESCALER; wdata = 8'h3E;         end
      4'd4:  begin is_write = 1'b1; addr = REG_TRELOAD_L;  wdata = 8'h1E;         end
      4'd5:  begin is_write = 1'b1; addr = REG_TRELOAD_H;  wdata = 8'h00;         end
      4'd6:  begin is_write = 1'b1; addr = REG_TXASK;      wdata = 8'h40;         end
      4'd7:  begin is_write = 1'b1; addr = REG_MODE;       wdata = 8'h3D;         end
      4'd8:  begin                  addr = REG_TXCONTROL;                         end
      4'd9:  begin is_write = 1'b1; addr = REG_TXCONTROL;  wdata = TXCTRL_ANTENNA_ON; is_rmw = 1'b1; end
      4'd10: begin                  addr = REG_VERSION;                           end
      default: ;
    endcase
  end

endmodule

// File: rtl/mfrc522_init_seq.sv
// MFRC522 register bring-up sequencer driving the SPI register-access command port.
// Optional macro MFRC522_VERSION_CHECK_EN rejects VersionReg values other than 0x91/0x92.
module mfrc522_init_seq
  import mfrc522_pkg::*;
#(
  parameter int POLL_LIMIT       = 255,
  parameter int CMD_TIMEOUT_CLKS = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] version,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_is_write,
  output logic [5:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_rdata,
  input  logic       cmd_done
);

  localparam int            TW       = (CMD_TIMEOUT_CLKS > 2) ? $clog2(CMD_TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(CMD_TIMEOUT_CLKS - 1);
  localparam logic [7:0]    POLL_MAX = 8'(POLL_LIMIT);

  logic [2:0]    state;
  logic [3:0]    step;
  logic [3:0]    rom_step;
  logic [7:0]    poll_cnt;
  logic [7:0]    poll_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    result;
  logic [7:0]    rmw_data;
  logic [7:0]    wdata_base;
  logic          rmw_sel;
  logic          cur_poll;
  logic          rom_is_write;
  logic [5:0]    rom_addr;
  logic [7:0]    rom_wdata;
  logic          rom_is_poll;
  logic          rom_is_rmw;
  logic          retry;
  logic          poll_fail;
  logic          last_step;
  logic          load_cmd;

  mfrc522_init_rom u_rom (
    .step     (rom_step),
    .is_write (rom_is_write),
    .addr     (rom_addr),
    .wdata    (rom_wdata),
    .is_poll  (rom_is_poll),
    .is_rmw   (rom_is_rmw)
  );

  assign cmd_wdata = rmw_sel ? (wdata_base | rmw_data) : wdata_base;

  // The ROM is addressed with the step about to be issued so the command
  // fields can be registered on the same edge that enters ISSUE.
  always_comb begin
    retry     = cur_poll && result[POWERDOWN_BIT];
    poll_nxt  = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
    poll_fail = retry && (poll_nxt == POLL_MAX);
    last_step = !retry && (step == STEP_LAST);
    rom_step  = step;
    load_cmd  = 1'b0;
    if (state == ST_IDLE) begin
      rom_step = '0;
      load_cmd = start;
    end else if (state == ST_EVAL) begin
      if (!retry) rom_step = step + 4'd1;
      load_cmd = !poll_fail && !last_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      step         <= '0;
      poll_cnt     <= '0;
      tmo_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      version      <= '0;
      cmd_valid    <= 1'b0;
      cmd_is_write <= 1'b0;
      cmd_addr     <= '0;
      wdata_base   <= '0;
      rmw_sel      <= 1'b0;
      cur_poll     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (load_cmd) begin
        cmd_valid    <= 1'b1;
        cmd_is_write <= rom_is_write;
        cmd_addr     <= rom_addr;
        wdata_base   <= rom_wdata;
        rmw_sel      <= rom_is_rmw;
        cur_poll     <= rom_is_poll;
        busy         <= 1'b1;
        state        <= ST_ISSUE;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_code <= ERR_NONE;
            step     <= '0;
            poll_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cmd_done) begin
            state <= ST_EVAL;
          end else if (tmo_cnt == TMO_LAST) begin
            err_code <= ERR_TIMEOUT;
            error    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_ERR;
          end
        end
        ST_EVAL: begin
          if (retry) poll_cnt <= poll_nxt;
          if (poll_fail) begin
            err_code <= ERR_POLL;
            error    <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_ERR;
          end else if (last_step) begin
            version <= result;
            busy    <= 1'b0;
`ifdef MFRC522_VERSION_CHECK_EN
            if (result != VERSION_V1 && result != VERSION_V2) begin
              err_code <= ERR_VERSION;
              error    <= 1'b1;
              state    <= ST_ERR;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
`else
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end else if (!retry) begin
            step <= step + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read results are plain data and need no reset.
  always_ff @(posedge clk) begin
    if (state == ST_WAIT && cmd_done) result <= cmd_rdata;
    if (state == ST_EVAL && step == STEP_RMW_READ) rmw_data <= result;
  end

endmodule

// File: tb/tb_mfrc522_init_seq.sv
// Bench for mfrc522_init_seq: mock register slave, list-based sequence model,
// per-cycle control timeline compare, and hand-computed literal checks.
module tb_mfrc522_init_seq;
  localparam int PL  = 4;
  localparam int TMO = 64;
  localparam int LAT = 20;
  localparam int PER = LAT + 3;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, error, cmd_valid, cmd_ready, cmd_is_write, cmd_done;
  logic [1:0] err_code;
  logic [7:0] version, cmd_wdata, cmd_rdata;
  logic [5:0] cmd_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mfrc522_init_seq #(.POLL_LIMIT(PL), .CMD_TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .version(version), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_write(cmd_is_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock slave configuration and command log
  int          busy_reads;
  int          polls_served;
  logic [7:0]  tx_val, ver_val;
  logic        hang_en;
  logic [5:0]  hang_addr;
  logic [14:0] log_q[$];
  int          acc_q[$];

  initial begin
    logic [14:0] c;
    logic [7:0]  rd;
    cmd_done  = 1'b0;
    cmd_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        c = {cmd_is_write, cmd_addr, cmd_wdata};
        log_q.push_back(c);
        acc_q.push_back(cyc);
        if (!(hang_en && cmd_addr == hang_addr)) begin
          rd = 8'h00;
          if (!c[14]) begin
            if (c[13:8] == 6'h01) begin
              rd = (busy_reads < 0 || polls_served < busy_reads) ? 8'h10 : 8'h00;
              polls_served++;
            end else if (c[13:8] == 6'h14) rd = tx_val;
            else if (c[13:8] == 6'h37) rd = ver_val;
          end
          repeat (LAT + 1) @(negedge clk);
          cmd_rdata = rd;
          cmd_done  = 1'b1;
          @(negedge clk);
          cmd_done  = 1'b0;
          cmd_rdata = 8'hEE;
        end
      end
    end
  end

  // Sequence model: expected command list, outcome and end-cycle offset
  logic [14:0] exp_q[$];
  int          exp_end;
  logic        exp_ok;
  logic [1:0]  exp_code;
  logic [7:0]  exp_version = 8'h00;

  task automatic build_model(input int br, input logic [7:0] tx, input logic [7:0] ver,
                             input logic he, input logic [5:0] ha);
    logic [14:0] tail [9];
    logic fail, hung;
    tail = '{ {1'b1,6'h2A,8'h8D}, {1'b1,6'h2B,8'h3E}, {1'b1,6'h2D,8'h1E}, {1'b1,6'h2C,8'h00},
              {1'b1,6'h15,8'h40}, {1'b1,6'h11,8'h3D}, {1'b0,6'h14,8'h00},
              {1'b1,6'h14,tx | 8'h03}, {1'b0,6'h37,8'h00} };
    exp_q.delete();
    exp_q.push_back({1'b1, 6'h01, 8'h0F});
    fail = 1'b0;
    hung = 1'b0;
    for (int k = 1; k <= PL; k++) begin
      exp_q.push_back({1'b0, 6'h01, 8'h00});
      if (!(br < 0 || k <= br)) break;
      if (k == PL) fail = 1'b1;
    end
    exp_ok   = 1'b1;
    exp_code = 2'b00;
    if (fail) begin
      exp_ok   = 1'b0;
      exp_code = 2'b01;
      exp_end  = 1 + exp_q.size() * PER;
    end else begin
      for (int j = 0; j < 9 && !hung; j++) begin
        exp_q.push_back(tail[j]);
        if (he && tail[j][14] && tail[j][13:8] == ha) hung = 1'b1;
      end
      if (hung) begin
        exp_ok   = 1'b0;
        exp_code = 2'b10;
        exp_end  = 1 + (exp_q.size() - 1) * PER + TMO + 1;
      end else begin
        exp_version = ver;
        exp_end     = 1 + exp_q.size() * PER;
`ifdef MFRC522_VERSION_CHECK_EN
        if (ver != 8'h91 && ver != 8'h92) begin
          exp_ok   = 1'b0;
          exp_code = 2'b11;
        end
`endif
      end
    end
  endtask

  // Per-cycle control timeline compare
  logic win = 1'b0;
  int   w_s = 0;
  initial begin
    int  off;
    logic eb, ed, ee, ev;
    forever begin
      @(negedge clk);
      if (win) begin
        off = cyc - w_s - 1;
        eb  = (cyc > w_s) && (cyc < w_s + exp_end);
        ed  = exp_ok && (cyc == w_s + exp_end);
        ee  = !exp_ok && (cyc == w_s + exp_end);
        ev  = (off >= 0) && (off % PER == 0) && (off / PER < exp_q.size());
        checks++;
        if ({busy, done, error, cmd_valid} !== {eb, ed, ee, ev}) begin
          failures++;
          $display("FAIL ctl_timeline cyc=%0d got busy/done/error/valid=%b%b%b%b want %b%b%b%b",
                   cyc - w_s, busy, done, error, cmd_valid, eb, ed, ee, ev);
        end
      end
    end
  end

  int   last_s, last_end;
  logic last_done;

  task automatic check(input string nm, input logic ok, input int got, input int want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic run_case(input string nm, input int br, input logic [7:0] tx, input logic [7:0] ver,
                          input logic he, input logic [5:0] ha, input logic extra);
    logic fin;
    build_model(br, tx, ver, he, ha);
    busy_reads = br; tx_val = tx; ver_val = ver; hang_en = he; hang_addr = ha; polls_served = 0;
    log_q.delete();
    acc_q.delete();
    @(negedge clk);
    last_s = cyc;
    w_s    = cyc;
    start  = 1'b1;
    win    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin   = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (done || error) fin = 1'b1;
      else begin
        start = extra && (i == 5);
        @(negedge clk);
      end
    end
    start     = 1'b0;
    last_end  = cyc;
    last_done = done;
    check({nm, "_completes"}, fin, fin, 1);
    repeat (2) @(negedge clk);
    win = 1'b0;
    check({nm, "_cmd_count"}, log_q.size() == exp_q.size(), log_q.size(), exp_q.size());
    if (log_q.size() == exp_q.size())
      foreach (exp_q[i])
        check($sformatf("%s_cmd%0d", nm, i),
              log_q[i][14:8] == exp_q[i][14:8] && (!exp_q[i][14] || log_q[i][7:0] == exp_q[i][7:0]),
              log_q[i], exp_q[i]);
    check({nm, "_err_code"}, err_code == exp_code, err_code, exp_code);
    check({nm, "_version"}, version == exp_version, version, exp_version);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    logic saw_2a, quiet;
    rst = 1'b1; start = 1'b0; cmd_ready = 1'b1;
    busy_reads = 0; polls_served = 0; tx_val = 8'h00; ver_val = 8'h00; hang_en = 1'b0; hang_addr = 6'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs",
          {busy, done, error, cmd_valid, cmd_is_write, cmd_addr, cmd_wdata, err_code, version} == '0,
          {busy, done, error, cmd_valid}, 0);

    run_case("nominal", 0, 8'h00, 8'h92, 1'b0, 6'h00, 1'b1);
    check("nominal_done", last_done == 1'b1, last_done, 1);
    check("nominal_version", version == 8'h92, version, 8'h92);
    check("nominal_total", last_end - last_s == 254, last_end - last_s, 254);
    check("nominal_first_valid", acc_q.size() > 1 && acc_q[0] - last_s == 1, acc_q[0] - last_s, 1);
    check("nominal_step_cost", acc_q.size() > 1 && acc_q[1] - acc_q[0] == 23, acc_q[1] - acc_q[0], 23);
    check("nominal_rmw_write", log_q.size() > 9 && log_q[9] == {1'b1, 6'h14, 8'h03}, log_q[9], 15'h5403);

    run_case("rmw", 0, 8'h80, 8'h91, 1'b0, 6'h00, 1'b0);
    check("rmw_write_83", log_q.size() > 9 && log_q[9] == {1'b1, 6'h14, 8'h83}, log_q[9], 15'h5483);

    run_case("poll3", 3, 8'h00, 8'h92, 1'b0, 6'h00, 1'b0);
    nrd = 0;
    foreach (log_q[i]) if (log_q[i][14:8] == {1'b0, 6'h01}) nrd++;
    check("poll3_reads", nrd == 4, nrd, 4);
    check("poll3_done", last_done == 1'b1, last_done, 1);

    run_case("poll_exhaust", -1, 8'h00, 8'h92, 1'b0, 6'h00, 1'b0);
    saw_2a = 1'b0;
    foreach (log_q[i]) if (log_q[i][14:8] == {1'b1, 6'h2A}) saw_2a = 1'b1;
    check("poll_exhaust_code", err_code == 2'b01, err_code, 1);
    check("poll_exhaust_no_2a", !saw_2a, saw_2a, 0);

    run_case("timeout", 0, 8'h00, 8'h92, 1'b1, 6'h2B, 1'b0);
    check("timeout_code", err_code == 2'b10, err_code, 2);
    check("timeout_latency", acc_q.size() > 0 && last_end - acc_q[acc_q.size()-1] == 65,
          last_end - acc_q[acc_q.size()-1], 65);

    run_case("version12", 0, 8'h00, 8'h12, 1'b0, 6'h00, 1'b0);
    check("version12_value", version == 8'h12, version, 8'h12);
`ifdef MFRC522_VERSION_CHECK_EN
    check("version12_code", err_code == 2'b11 && !last_done, err_code, 3);
`else
    check("version12_code", err_code == 2'b00 && last_done, err_code, 0);
`endif

    // Reset during WAIT of the first command
    busy_reads = 0; polls_served = 0; hang_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_busy", busy == 1'b1 && cmd_valid == 1'b0, busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_outputs",
          {busy, done, error, cmd_valid, cmd_is_write, cmd_addr, cmd_wdata, err_code, version} == '0,
          {busy, done, error, cmd_valid}, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy || cmd_valid || done || error) quiet = 1'b0;
    end
    check("rst_stale_done_ignored", quiet, quiet, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
